// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade scheduler for NCH PWM channels sharing one period counter.
// Optional continuous up/down fading is built when PWM_FADE_LOOP_EN is defined.
module pwm_fade_ctrl #(
    parameter int NCH    = 4,
    parameter int PERIOD = 100,
    parameter int DW     = 8,
    parameter int STEP   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cyc_end,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [$clog2(NCH)-1:0] req_ch,
    input  logic [DW-1:0]          req_target,
    input  logic                   req_loop,
    output logic [NCH*DW-1:0]      duty_flat,
    output logic [NCH-1:0]         busy,
    output logic [NCH-1:0]         done,
    output logic                   overrun
);

    localparam int CW = $clog2(NCH);
    localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);
    localparam logic [DW:0]   STEP_W   = (DW + 1)'(STEP);
    localparam logic [DW:0]   PERIOD_W = (DW + 1)'(PERIOD);
    localparam logic [DW-1:0] PERIOD_D = DW'(PERIOD);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic            pend_q, pend_d;
    logic            overrun_q, overrun_d;
    logic [DW-1:0]   duty_q   [NCH];
    logic [DW-1:0]   duty_d   [NCH];
    logic [DW-1:0]   target_q [NCH];
    logic [DW-1:0]   target_d [NCH];
    logic [NCH-1:0]  busy_q, busy_d;
    logic [NCH-1:0]  done_q, done_d;
`ifdef PWM_FADE_LOOP_EN
    logic [NCH-1:0]  loop_q, loop_d;
`endif

    logic [DW-1:0]   req_clamped;
    logic [DW:0]     cur_w, tgt_w, diff_w, nxt_w;

    assign req_clamped = ({1'b0, req_target} > PERIOD_W) ? PERIOD_D : req_target;

    // Shared step engine: operates on the channel currently visited by the scan.
    always_comb begin
        cur_w  = {1'b0, duty_q[ch_q]};
        tgt_w  = {1'b0, target_q[ch_q]};
        diff_w = '0;
        nxt_w  = cur_w;
        if (tgt_w >= cur_w) begin
            diff_w = tgt_w - cur_w;
            nxt_w  = (diff_w <= STEP_W) ? tgt_w : cur_w + STEP_W;
        end else begin
            diff_w = cur_w - tgt_w;
            nxt_w  = (diff_w <= STEP_W) ? tgt_w : cur_w - STEP_W;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        pend_d    = pend_q;
        overrun_d = overrun_q;
        duty_d    = duty_q;
        target_d  = target_q;
        busy_d    = busy_q;
        done_d    = '0;
`ifdef PWM_FADE_LOOP_EN
        loop_d    = loop_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d[req_ch] = req_clamped;
                    busy_d[req_ch]   = (req_clamped != duty_q[req_ch]);
                    done_d[req_ch]   = (req_clamped == duty_q[req_ch]);
`ifdef PWM_FADE_LOOP_EN
                    loop_d[req_ch]   = req_loop;
`endif
                end
                if (cyc_end) begin
                    state_d = SCAN;
                    ch_d    = '0;
                end
            end
            SCAN: begin
                if (cyc_end) begin
                    pend_d    = 1'b1;
                    overrun_d = 1'b1;
                end
                if (busy_q[ch_q]) begin
                    duty_d[ch_q] = nxt_w[DW-1:0];
                    if (nxt_w == tgt_w) begin
                        done_d[ch_q] = 1'b1;
`ifdef PWM_FADE_LOOP_EN
                        // Looping channels bounce between the end stops and stay busy.
                        if (loop_q[ch_q] && tgt_w == PERIOD_W) begin
                            target_d[ch_q] = '0;
                        end else if (loop_q[ch_q] && tgt_w == '0) begin
                            target_d[ch_q] = PERIOD_D;
                        end else begin
                            busy_d[ch_q] = 1'b0;
                        end
`else
                        busy_d[ch_q] = 1'b0;
`endif
                    end
                end
                if (ch_q == LAST_CH) begin
                    if (pend_q || cyc_end) begin
                        ch_d   = '0;
                        pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= '0;
            done_q    <= '0;
`ifdef PWM_FADE_LOOP_EN
            loop_q    <= '0;
`endif
            for (int unsigned k = 0; k < NCH; k++) begin
                duty_q[k]   <= '0;
                target_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef PWM_FADE_LOOP_EN
            loop_q    <= loop_d;
`endif
            for (int unsigned k = 0; k < NCH; k++) begin
                duty_q[k]   <= duty_d[k];
                target_q[k] <= target_d[k];
            end
        end
    end

    always_comb begin
        duty_flat = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            duty_flat[k*DW +: DW] = duty_q[k];
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

`ifndef PWM_FADE_LOOP_EN
    logic unused_loop;
    assign unused_loop = req_loop;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: a per-channel model pushes expected duty/done
// events into a scoreboard that is checked against the DUT on every falling edge.
module tb_pwm_fade_ctrl;

    localparam int NCH    = 4;
    localparam int PERIOD = 100;
    localparam int DW     = 8;
    localparam int STEP   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cyc_end = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_ch = '0;
    logic [DW-1:0]     req_target = '0;
    logic              req_loop = 1'b0;
    logic [NCH*DW-1:0] duty_flat;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;
    logic              overrun;

    pwm_fade_ctrl #(.NCH(NCH), .PERIOD(PERIOD), .DW(DW), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .cyc_end(cyc_end),
        .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch),
        .req_target(req_target), .req_loop(req_loop),
        .duty_flat(duty_flat), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        int          ch;
        int          duty;
        bit          done;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   sh_duty [NCH];
    int   mduty   [NCH];
    int   mtgt    [NCH];
    bit   mbusy   [NCH];
    bit   mloop   [NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [NCH-1:0] exp_done;
        exp_t e;
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) sh_duty[k] = 0;
            return;
        end
        if (!chk_en) return;
        exp_done = '0;
        while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            sh_duty[e.ch] = e.duty;
            if (e.done) exp_done[e.ch] = 1'b1;
        end
        for (int k = 0; k < NCH; k++)
            check($sformatf("duty%0d@%0d", k, cyc), 32'(duty_flat[k*DW +: DW]), 32'(sh_duty[k]));
        check($sformatf("done@%0d", cyc), 32'(done), 32'(exp_done));
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            mduty[k] = 0; mtgt[k] = 0; mbusy[k] = 0; mloop[k] = 0;
        end
        sbq.delete();
    endtask

    task automatic model_accept(input int ch, input int tgt, input bit lp, input int unsigned n);
        int c;
        exp_t e;
        c = (tgt > PERIOD) ? PERIOD : tgt;
        mtgt[ch] = c;
`ifdef PWM_FADE_LOOP_EN
        mloop[ch] = lp;
`else
        mloop[ch] = 1'b0;
        if (lp) mloop[ch] = 1'b0;
`endif
        if (c == mduty[ch]) begin
            mbusy[ch] = 1'b0;
            e.cyc = n + 1; e.ch = ch; e.duty = c; e.done = 1'b1;
            sbq.push_back(e);
        end else begin
            mbusy[ch] = 1'b1;
        end
    endtask

    // Channel k of a scan whose cyc_end is driven at bench cycle n is observed at n+2+k.
    task automatic model_scan(input int unsigned base);
        exp_t e;
        for (int k = 0; k < NCH; k++) begin
            if (mbusy[k]) begin
                int d, t, nd;
                d = mduty[k];
                t = mtgt[k];
                if (t > d) nd = (t - d <= STEP) ? t : d + STEP;
                else       nd = (d - t <= STEP) ? t : d - STEP;
                e.cyc = base + k; e.ch = k; e.duty = nd; e.done = (nd == t);
                sbq.push_back(e);
                mduty[k] = nd;
                if (nd == t) begin
                    if (mloop[k] && t == PERIOD)  mtgt[k] = 0;
                    else if (mloop[k] && t == 0)  mtgt[k] = PERIOD;
                    else                          mbusy[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic send(input int ch, input int tgt, input bit lp, output int stalls);
        req_valid  = 1'b1;
        req_ch     = 2'(ch);
        req_target = DW'(tgt);
        req_loop   = lp;
        stalls     = 0;
        while (!req_ready && stalls < 50) begin
            tick();
            stalls++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        model_accept(ch, tgt, lp, cyc);
        tick();
        req_valid = 1'b0;
        req_loop  = 1'b0;
    endtask

    task automatic pulse();
        cyc_end = 1'b1;
        model_scan(cyc + 2);
        tick();
        cyc_end = 1'b0;
    endtask

    function automatic logic [31:0] mbusy_vec();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < NCH; k++) v[k] = mbusy[k];
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int unsigned n;
        model_reset();

        // Reset state, both while held and after release
        wait_cyc(3);
        check("rst_duty", duty_flat, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_done", 32'(done), 32'd0);

        // ch0 0->20 over four periods; ch1 brought to 20 alongside
        send(0, 20, 1'b0, st);
        send(1, 20, 1'b0, st);
        check("busy_after_cmd", 32'(busy), mbusy_vec());
        repeat (4) begin
            pulse();
            wait_cyc(99);
        end
        check("ch0_final", 32'(duty_flat[7:0]), 32'd20);
        check("busy_ch0_fell", 32'(busy), mbusy_vec());

        // ch1 20->7 with clamped last step, then an over-range target
        send(1, 7, 1'b0, st);
        repeat (3) begin
            pulse();
            wait_cyc(9);
        end
        check("ch1_down", 32'(duty_flat[15:8]), 32'd7);
        send(1, 150, 1'b0, st);
        check("ch1_busy_150", 32'(busy[1]), 32'd1);
        repeat (19) begin
            pulse();
            wait_cyc(9);
        end
        check("ch1_clamped", 32'(duty_flat[15:8]), 32'd100);
        check("ch1_idle", 32'(busy[1]), 32'd0);
        // Target equal to current duty: immediate done, never busy
        send(1, 100, 1'b0, st);
        check("ch1_same_busy", 32'(busy[1]), 32'd0);

        // ch2 updates at T+3; a command issued during the scan stalls until IDLE
        send(2, 30, 1'b0, st);
        pulse();
        check("ready_in_scan", 32'(req_ready), 32'd0);
        send(3, 40, 1'b0, st);
        check("stall_cycles", 32'(st), 32'(NCH));
        wait_cyc(10);

        // Command and cyc_end in the same cycle: accept first, scan sees new target
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_ch = 2'd0; req_target = 8'd10; req_loop = 1'b0;
        cyc_end = 1'b1;
        model_accept(0, 10, 1'b0, cyc);
        model_scan(cyc + 2);
        tick();
        cyc_end = 1'b0; req_valid = 1'b0;
        wait_cyc(10);

        // Overrun: second cyc_end one clock after the first gives two back-to-back scans
        check("overrun_pre", 32'(overrun), 32'd0);
        n = cyc;
        cyc_end = 1'b1;
        model_scan(n + 2);
        tick();
        cyc_end = 1'b0;
        tick();
        cyc_end = 1'b1;
        tick();
        cyc_end = 1'b0;
        model_scan(n + 6);
        wait_cyc(20);
        check("overrun_set", 32'(overrun), 32'd1);
        check("busy_after_ovr", 32'(busy), mbusy_vec());
        check("sb_drain_ovr", 32'(sbq.size()), 32'd0);

        // Reset in the middle of a scan clears everything at once
        chk_en = 1'b0;
        cyc_end = 1'b1;
        tick();
        cyc_end = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("midrst_duty", duty_flat, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // Loop fade on ch0 (stops at 100 when the loop feature is not built)
        send(0, 100, 1'b1, st);
        repeat (45) begin
            pulse();
            wait_cyc(7);
        end
`ifdef PWM_FADE_LOOP_EN
        check("loop_end_duty", 32'(duty_flat[7:0]), 32'd25);
        check("loop_end_busy", 32'(busy[0]), 32'd1);
`else
        check("loop_end_duty", 32'(duty_flat[7:0]), 32'd100);
        check("loop_end_busy", 32'(busy[0]), 32'd0);
`endif

        wait_cyc(10);
        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
